// File: rtl/serial_sym_rx.sv
// Serial receiver: start bit, SYMS_PER_FRAME 2-bit symbols (MSB first), stop bit.
// Completed symbols go into a first-word fall-through FIFO for a downstream consumer.
module serial_sym_rx #(
  parameter int SYMS_PER_FRAME = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       rx_bit,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);
  localparam int SW = (SYMS_PER_FRAME > 1) ? $clog2(SYMS_PER_FRAME) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] LAST_SYM = SW'(SYMS_PER_FRAME - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] cnt, cnt_nx;
  logic          phase, phase_nx;
  logic          msb, msb_nx;
  logic          push, done_set, err_set;
  logic [1:0]    run_q;

  // Release of rst_n ripples through two flops before a start bit is honoured.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run_q <= 2'b00;
    else        run_q <= {run_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      phase      <= 1'b0;
      msb        <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      phase      <= phase_nx;
      msb        <= msb_nx;
      frame_done <= done_set;
      frame_err  <= err_set;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    phase_nx = phase;
    msb_nx   = msb;
    push     = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: if (run_q[1] && !rx_bit) begin
          state_nx = DATA;
          cnt_nx   = '0;
          phase_nx = 1'b0;
        end
        DATA: if (!phase) begin
          msb_nx   = rx_bit;
          phase_nx = 1'b1;
        end else begin
          push     = 1'b1;
          phase_nx = 1'b0;
          if (cnt == LAST_SYM) begin
            cnt_nx   = '0;
            state_nx = STOP;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        STOP: begin
          state_nx = IDLE;
          if (rx_bit) done_set = 1'b1;
          else        err_set  = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  logic [FIFO_DEPTH-1:0][1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, wr_en;

  assign full      = (count == FULL_CNT);
  assign sym_valid = (count != '0);
  assign pop       = sym_valid & sym_ready;
  // A full FIFO still accepts the new symbol when the head leaves on the same edge.
  assign wr_en     = push & (~full | pop);
  assign sym_out   = sym_valid ? mem[rd_ptr] : 2'b00;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= {msb, rx_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_sym_rx.sv
// Randomised bench for serial_sym_rx: the driver annotates each strobe with its
// meaning in the frame, and a queue-based model predicts FIFO and pulse outputs.
module tb_serial_sym_rx;
  localparam int SPF   = 4;
  localparam int DEPTH = 4;

  typedef enum {A_NONE, A_START, A_PUSH, A_OK, A_ERR} ann_t;

  logic       clk = 1'b0;
  logic       rst_n, bit_en, rx_bit, sym_ready;
  logic [1:0] sym_out;
  logic       sym_valid, frame_done, frame_err, overflow, busy;

  int checks = 0, errors = 0;
  int q[$];
  bit m_ovf, m_busy, m_done, m_err;
  int rmode, gap_max;

  always #5 clk = ~clk;

  serial_sym_rx #(.SYMS_PER_FRAME(SPF), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_bit(rx_bit),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("sym_valid", sym_valid, (q.size() > 0));
    chk("sym_out", sym_out, (q.size() > 0) ? q[0] : 0);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_done);
    chk("frame_err", frame_err, m_err);
    chk("overflow", overflow, m_ovf);
  endtask

  function automatic bit rdy();
    case (rmode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock: drive inputs, advance the model across the edge, check after it.
  task automatic cycle(input bit be, input bit rb, input bit rd, input ann_t a, input int s = 0);
    int n;
    bit pop;
    bit_en = be; rx_bit = rb; sym_ready = rd;
    @(posedge clk);
    n   = q.size();
    pop = (n > 0) && rd;
    if (pop) void'(q.pop_front());
    if (a == A_PUSH) begin
      if (n == DEPTH && !pop) m_ovf = 1'b1;
      else                    q.push_back(s);
    end
    m_done = (a == A_OK);
    m_err  = (a == A_ERR);
    if (a == A_START) m_busy = 1'b1;
    if (a == A_OK || a == A_ERR) m_busy = 1'b0;
    #1;
    compare_all();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, gap_max)) cycle(1'b0, 1'($urandom_range(0, 1)), rdy(), A_NONE);
  endtask

  task automatic send_frame(input logic [31:0] syms, input bit stop);
    logic [1:0] sv;
    cycle(1'b1, 1'b0, rdy(), A_START); gap();
    for (int i = 0; i < SPF; i++) begin
      sv = syms[2*i +: 2];
      cycle(1'b1, sv[1], rdy(), A_NONE); gap();
      cycle(1'b1, sv[0], rdy(), A_PUSH, int'(sv)); gap();
    end
    cycle(1'b1, stop, rdy(), stop ? A_OK : A_ERR); gap();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym_out", sym_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done_err", {frame_done, frame_err}, 0);
    q.delete(); m_ovf = 0; m_busy = 0; m_done = 0; m_err = 0;
    repeat (2) cycle(1'b0, 1'b1, rdy(), A_NONE);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b1, rdy(), A_NONE);
  endtask

  initial begin
    int popped;
    rst_n = 1'b0; bit_en = 1'b0; rx_bit = 1'b1; sym_ready = 1'b0;
    rmode = 1; gap_max = 0;
    #2;
    do_reset();

    // basic frame 0,1,2,3 with good stop, then the same with a bad stop
    send_frame(32'hE4, 1'b1);
    chk("busy_after_frame", busy, 0);
    send_frame(32'hE4, 1'b0);
    chk("no_done_on_err", frame_done, 0);

    // consumer stalled: 3,3,3,3 fills the FIFO, the first 1 overflows
    rmode = 0;
    send_frame(32'hFF, 1'b1);
    send_frame(32'h55, 1'b1);
    chk("ovf_sticky", overflow, 1);
    popped = 0;
    for (int i = 0; i < 8; i++) begin
      if (sym_valid) begin
        popped++;
        chk("drain_val", sym_out, 3);
      end
      cycle(1'b0, 1'b1, 1'b1, A_NONE);
    end
    chk("drain_cnt", popped, 4);

    // full FIFO, pop on the same edge a symbol 2 completes
    do_reset();
    rmode = 0;
    send_frame(32'hE4, 1'b1);
    chk("full_head", sym_out, 0);
    cycle(1'b1, 1'b0, 1'b0, A_START);
    cycle(1'b1, 1'b1, 1'b0, A_NONE);
    cycle(1'b1, 1'b0, 1'b1, A_PUSH, 2);
    chk("push_pop_full_ovf", overflow, 0);
    chk("push_pop_full_head", sym_out, 1);
    for (int i = 1; i < SPF; i++) begin
      cycle(1'b1, 1'b1, 1'b1, A_NONE);
      cycle(1'b1, 1'b0, 1'b1, A_PUSH, 2);
    end
    cycle(1'b1, 1'b1, 1'b1, A_OK);
    rmode = 1;
    repeat (6) cycle(1'b0, 1'b1, 1'b1, A_NONE);

    // reset mid-frame, then a clean 2,2,2,2 frame
    cycle(1'b1, 1'b0, 1'b1, A_START);
    cycle(1'b1, 1'b1, 1'b1, A_NONE);
    cycle(1'b1, 1'b0, 1'b1, A_PUSH, 2);
    cycle(1'b1, 1'b1, 1'b1, A_NONE);
    do_reset();
    send_frame(32'hAA, 1'b1);

    // line toggling without strobes while idle
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i), 1'b1, A_NONE);
    chk("idle_busy", busy, 0);
    chk("idle_valid", sym_valid, 0);

    // randomised traffic
    do_reset();
    gap_max = 3;
    for (int f = 0; f < 60; f++) begin
      rmode = ($urandom_range(0, 9) == 0) ? 0 : 2;
      if ($urandom_range(0, 2) == 0) cycle(1'b1, 1'b1, rdy(), A_NONE);
      send_frame($urandom, $urandom_range(0, 5) != 0);
    end
    rmode = 1;
    repeat (8) cycle(1'b0, 1'b1, 1'b1, A_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
